// File: rtl/pll_reset_ctrl.sv
// Board PLL reset sequencer: holds the PLL in reset, qualifies lock over a
// stability window, retries on lock timeout and owns the system reset.
module pll_reset_ctrl #(
    parameter int PLL_RESET_CYCLES   = 16,
    parameter int LOCK_TIMEOUT       = 65536,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES        = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       restart,
    input  logic       clear,
    output logic       pll_resetb,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fail,
    output logic       lock_lost,
    output logic [3:0] retry_count
);
    localparam int MAX_A   = (PLL_RESET_CYCLES > LOCK_TIMEOUT) ? PLL_RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] RST_LAST  = CW'(PLL_RESET_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAILED
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    sync_q;
    logic          lock_sync;
    logic          started;
    logic [3:0]    retry_nxt;
    logic          lost_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], locked};
    end

    assign lock_sync = sync_q[1];

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_count;
        lost_nxt  = lock_lost;
        if (clear) lost_nxt = 1'b0;
        case (state)
            S_PLL_RST: begin
                if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (lock_sync) begin
                    state_nxt = S_STABLE;
                end else if (cnt == TMO_LAST) begin
                    if (retry_count == RETRY_MAX) begin
                        state_nxt = S_FAILED;
                    end else begin
                        retry_nxt = retry_count + 4'd1;
                        state_nxt = S_PLL_RST;
                    end
                end
            end
            S_STABLE: begin
                // a lock drop here is treated as still settling, not a failed attempt
                if (!lock_sync)           state_nxt = S_WAIT_LOCK;
                else if (cnt == STB_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!lock_sync) begin
                    lost_nxt  = 1'b1;
                    retry_nxt = 4'd0;
                    state_nxt = S_PLL_RST;
                end
            end
            S_FAILED: begin
                if (restart) begin
                    retry_nxt = 4'd0;
                    state_nxt = S_PLL_RST;
                end
            end
            default: state_nxt = S_PLL_RST;
        endcase
    end

    // The first edge after reset release acts as entry into PLL_RST, so the
    // initial attempt holds the PLL in reset for the same window as a retry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_PLL_RST;
            cnt         <= '0;
            started     <= 1'b0;
            pll_resetb  <= 1'b0;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fail        <= 1'b0;
            lock_lost   <= 1'b0;
            retry_count <= 4'd0;
        end else begin
            started <= 1'b1;
            if (started) begin
                state       <= state_nxt;
                cnt         <= (state_nxt != state) ? '0 : cnt + CW'(1);
                pll_resetb  <= (state_nxt == S_WAIT_LOCK) || (state_nxt == S_STABLE) ||
                               (state_nxt == S_RUN);
                sys_reset_n <= (state_nxt == S_RUN);
                ready       <= (state_nxt == S_RUN);
                fail        <= (state_nxt == S_FAILED);
                lock_lost   <= lost_nxt;
                retry_count <= retry_nxt;
            end
        end
    end
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Bench for pll_reset_ctrl: per-edge stimulus/expectation tables replayed
// through a scoreboard, plus hand-written restart and async-reset sequences.
module tb_pll_reset_ctrl;
    logic       clock   = 1'b0;
    logic       reset_n = 1'b1;
    logic       locked  = 1'b0;
    logic       restart = 1'b0;
    logic       clear   = 1'b0;
    logic       pll_resetb, sys_reset_n, ready, fail, lock_lost;
    logic [3:0] retry_count;

    always #5 clock = ~clock;

    pll_reset_ctrl #(
        .PLL_RESET_CYCLES  (4),
        .LOCK_TIMEOUT      (32),
        .LOCK_STABLE_CYCLES(8),
        .MAX_RETRIES       (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .locked     (locked),
        .restart    (restart),
        .clear      (clear),
        .pll_resetb (pll_resetb),
        .sys_reset_n(sys_reset_n),
        .ready      (ready),
        .fail       (fail),
        .lock_lost  (lock_lost),
        .retry_count(retry_count)
    );

    // lck: 1/0 drives locked, -1 leaves it; rs/cl are one-cycle pulses
    typedef struct { int edge_no; int lck; bit rs; bit cl; } stim_t;
    typedef struct { string name; int edge_no; logic [8:0] exp; } chk_t;

    stim_t sb_stim[$];
    chk_t  sb_exp[$];
    int    ecnt;
    int    checks   = 0;
    int    failures = 0;

    function automatic logic [8:0] ev(input bit prb, input bit srn, input bit rdy,
                                      input bit fl, input bit ll, input int rc);
        return {prb, srn, rdy, fl, ll, 4'(rc)};
    endfunction

    function automatic logic [8:0] obs();
        return {pll_resetb, sys_reset_n, ready, fail, lock_lost, retry_count};
    endfunction

    function automatic stim_t mk_s(input int e, input int l, input bit r, input bit c);
        stim_t s;
        s.edge_no = e; s.lck = l; s.rs = r; s.cl = c;
        return s;
    endfunction

    function automatic chk_t mk_c(input string n, input int e, input logic [8:0] x);
        chk_t c;
        c.name = n; c.edge_no = e; c.exp = x;
        return c;
    endfunction

    task automatic cmp(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b (prb,srn,rdy,fail,lost,retry[3:0])", name, act, exp);
        end
    endtask

    // Entered just after a negedge; applies stimulus for edge ecnt, then
    // checks outputs 1ns after that edge and returns after the next negedge.
    task automatic step();
        stim_t s;
        chk_t  c;
        restart = 1'b0;
        clear   = 1'b0;
        while (sb_stim.size() > 0 && sb_stim[0].edge_no <= ecnt) begin
            s = sb_stim.pop_front();
            if (s.lck >= 0) locked = s.lck[0];
            if (s.rs) restart = 1'b1;
            if (s.cl) clear = 1'b1;
        end
        @(posedge clock);
        #1;
        while (sb_exp.size() > 0 && sb_exp[0].edge_no == ecnt) begin
            c = sb_exp.pop_front();
            cmp(c.name, obs(), c.exp);
        end
        ecnt++;
        @(negedge clock);
    endtask

    task automatic load(input stim_t st[$], input chk_t ck[$]);
        ecnt    = 0;
        sb_stim = st;
        sb_exp  = ck;
    endtask

    task automatic play(input int n);
        chk_t c;
        for (int i = 0; i < n; i++) step();
        while (sb_exp.size() > 0) begin
            c = sb_exp.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: edge %0d never reached", c.name, c.edge_no);
        end
        sb_stim.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        locked  = 1'b0;
        restart = 1'b0;
        clear   = 1'b0;
        repeat (2) @(negedge clock);
        cmp("reset_values", obs(), ev(0, 0, 0, 0, 0, 0));
        reset_n = 1'b1;
        ecnt    = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t bu_s[$], gl_s[$], to_s[$], rs_s[$], ll_s[$];
        chk_t  bu_c[$], gl_c[$], to_c[$], rs_c[$], ll_c[$];
        int    r;
        bit    found;

        // normal bring-up: lock before edge 14 -> STABLE at 16, RUN at 24
        bu_s.push_back(mk_s(14, 1, 0, 0));
        bu_c.push_back(mk_c("bu_pllrst_e3", 3,  ev(0, 0, 0, 0, 0, 0)));
        bu_c.push_back(mk_c("bu_prb_e4",    4,  ev(1, 0, 0, 0, 0, 0)));
        bu_c.push_back(mk_c("bu_wait_e15",  15, ev(1, 0, 0, 0, 0, 0)));
        bu_c.push_back(mk_c("bu_stable_e23",23, ev(1, 0, 0, 0, 0, 0)));
        bu_c.push_back(mk_c("bu_run_e24",   24, ev(1, 1, 1, 0, 0, 0)));
        bu_c.push_back(mk_c("bu_run_e29",   29, ev(1, 1, 1, 0, 0, 0)));

        // one-cycle glitch before edge 18, re-lock before 19 -> RUN at 29
        gl_s.push_back(mk_s(14, 1, 0, 0));
        gl_s.push_back(mk_s(18, 0, 0, 0));
        gl_s.push_back(mk_s(19, 1, 0, 0));
        gl_c.push_back(mk_c("gl_stable_e17", 17, ev(1, 0, 0, 0, 0, 0)));
        gl_c.push_back(mk_c("gl_norun_e24",  24, ev(1, 0, 0, 0, 0, 0)));
        gl_c.push_back(mk_c("gl_norun_e28",  28, ev(1, 0, 0, 0, 0, 0)));
        gl_c.push_back(mk_c("gl_run_e29",    29, ev(1, 1, 1, 0, 0, 0)));

        // no lock: attempts at 0, 36, 72; FAILED from 108; later inputs ignored
        to_s.push_back(mk_s(120, -1, 0, 1));
        to_s.push_back(mk_s(125, 1, 0, 0));
        to_s.push_back(mk_s(130, 0, 0, 0));
        to_c.push_back(mk_c("to_rst_e3",    3,   ev(0, 0, 0, 0, 0, 0)));
        to_c.push_back(mk_c("to_wait_e4",   4,   ev(1, 0, 0, 0, 0, 0)));
        to_c.push_back(mk_c("to_wait_e35",  35,  ev(1, 0, 0, 0, 0, 0)));
        to_c.push_back(mk_c("to_retry1_e36",36,  ev(0, 0, 0, 0, 0, 1)));
        to_c.push_back(mk_c("to_rst_e39",   39,  ev(0, 0, 0, 0, 0, 1)));
        to_c.push_back(mk_c("to_wait_e40",  40,  ev(1, 0, 0, 0, 0, 1)));
        to_c.push_back(mk_c("to_wait_e71",  71,  ev(1, 0, 0, 0, 0, 1)));
        to_c.push_back(mk_c("to_retry2_e72",72,  ev(0, 0, 0, 0, 0, 2)));
        to_c.push_back(mk_c("to_rst_e75",   75,  ev(0, 0, 0, 0, 0, 2)));
        to_c.push_back(mk_c("to_wait_e76",  76,  ev(1, 0, 0, 0, 0, 2)));
        to_c.push_back(mk_c("to_wait_e107", 107, ev(1, 0, 0, 0, 0, 2)));
        to_c.push_back(mk_c("to_failed_e108",108,ev(0, 0, 0, 1, 0, 2)));
        to_c.push_back(mk_c("to_stuck_e140",140, ev(0, 0, 0, 1, 0, 2)));

        // restart pulse from FAILED
        rs_s.push_back(mk_s(2, -1, 1, 0));
        rs_c.push_back(mk_c("rs_failed_e1", 1, ev(0, 0, 0, 1, 0, 2)));
        rs_c.push_back(mk_c("rs_left_e3",   3, ev(0, 0, 0, 0, 0, 0)));

        // lock loss in RUN, relock, clear, then loss coinciding with clear
        ll_s.push_back(mk_s(3,  0, 0, 0));
        ll_s.push_back(mk_s(12, 1, 0, 0));
        ll_s.push_back(mk_s(25, -1, 0, 1));
        ll_s.push_back(mk_s(30, 0, 0, 0));
        ll_s.push_back(mk_s(32, -1, 0, 1));
        ll_s.push_back(mk_s(40, 1, 0, 0));
        ll_s.push_back(mk_s(45, -1, 1, 0));
        ll_c.push_back(mk_c("ll_run_e4",     4,  ev(1, 1, 1, 0, 0, 0)));
        ll_c.push_back(mk_c("ll_lost_e5",    5,  ev(0, 0, 0, 0, 1, 0)));
        ll_c.push_back(mk_c("ll_stable_e21", 21, ev(1, 0, 0, 0, 1, 0)));
        ll_c.push_back(mk_c("ll_rerun_e22",  22, ev(1, 1, 1, 0, 1, 0)));
        ll_c.push_back(mk_c("ll_sticky_e24", 24, ev(1, 1, 1, 0, 1, 0)));
        ll_c.push_back(mk_c("ll_clear_e25",  25, ev(1, 1, 1, 0, 0, 0)));
        ll_c.push_back(mk_c("ll_run_e31",    31, ev(1, 1, 1, 0, 0, 0)));
        ll_c.push_back(mk_c("ll_setwins_e32",32, ev(0, 0, 0, 0, 1, 0)));
        ll_c.push_back(mk_c("ll_stable_e49", 49, ev(1, 0, 0, 0, 1, 0)));
        ll_c.push_back(mk_c("ll_run_e50",    50, ev(1, 1, 1, 0, 1, 0)));

        do_reset();
        load(bu_s, bu_c); play(30);

        do_reset();
        load(gl_s, gl_c); play(31);

        do_reset();
        load(to_s, to_c); play(141);

        load(rs_s, rs_c); play(4);
        found = 1'b0;
        r     = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (pll_resetb === 1'b1) begin
                found = 1'b1;
                r     = ecnt - 1;
            end
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL rs_prb_rise: pll_resetb still %b after 20 edges, want 1", pll_resetb);
        end else begin
            sb_stim.push_back(mk_s(r + 10, 1, 0, 0));
            sb_exp.push_back(mk_c("rs_stable_pre_run", r + 19, ev(1, 0, 0, 0, 0, 0)));
            sb_exp.push_back(mk_c("rs_run",            r + 20, ev(1, 1, 1, 0, 0, 0)));
            play(r + 21 - ecnt);
        end

        load(ll_s, ll_c); play(52);

        // async reset between edges while in RUN
        @(posedge clock);
        #1;
        cmp("ar_pre_run", obs(), ev(1, 1, 1, 0, 1, 0));
        #1;
        reset_n = 1'b0;
        #1;
        cmp("ar_immediate", obs(), ev(0, 0, 0, 0, 0, 0));
        do_reset();
        load(bu_s, bu_c); play(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
